bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
- Parameters (one per line: name, default, meaning)
  - REQ-001 WIDTH, 8, word width in bits; the block SHALL support any WIDTH >= 2.
  - REQ-002 MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- Ports (one per line: name, direction, width, meaning)
  - REQ-003 clk  input  1  single clock; all state changes on its rising edge.
  - REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
  - REQ-005 in_data  input  WIDTH  parallel word to serialize.
  - REQ-006 in_valid  input  1  in_data holds a word.
  - REQ-007 in_ready  output  1  block can take a word this cycle.
  - REQ-008 sout  output  1  serial bit stream, one bit per clock, registered.
  - REQ-009 sout_valid  output  1  sout carries a data bit, registered.
  - REQ-010 word_done  output  1  one-cycle pulse with the last bit of each word, registered.
  - REQ-011 busy  output  1  shift register or hold buffer occupied.

Function
- REQ-012 Word accepted SHALL mean in_valid=1 and in_ready=1 at a rising clk edge; no other condition consumes a word.
- REQ-013 Storage SHALL be a WIDTH-bit shift register (SR) plus a one-word hold buffer (HB); bit counter SHALL be $clog2(WIDTH) bits, counting 0..WIDTH-1.
- REQ-014 FSM states: IDLE (SR empty) and SHIFT (SR emitting).
- REQ-015 IDLE -> SHIFT on an accepted word; the word loads into SR and its first bit appears on sout with sout_valid=1 in the next cycle (latency 1 cycle).
- REQ-016 In SHIFT, each bit SHALL be held for exactly one cycle; bit order per MSB_FIRST.
- REQ-017 A word accepted while in SHIFT SHALL load into HB, unless SR is on its last bit and HB is empty, in which case it loads directly into SR.
- REQ-018 After SR's last bit, if HB is full, HB SHALL move into SR so the first bit of the next word follows with no gap (sout_valid stays 1); HB becomes empty.
- REQ-019 After SR's last bit with HB empty and no word accepted, FSM SHALL return to IDLE; sout=0 and sout_valid=0 the following cycle.
- REQ-020 in_ready SHALL be 1 when HB is empty and reset is high; 0 otherwise. It is a combinational function of registered state and reset only, not of in_valid.
- REQ-021 word_done SHALL be 1 exactly in the cycle where the bit at position WIDTH-1 of the emitted sequence is on sout.
- REQ-022 busy SHALL be 1 whenever FSM is in SHIFT or HB is full.
- REQ-023 When sout_valid=0, sout SHALL be 0.
- REQ-024 in_data changes while in_valid=1 and in_ready=0 SHALL have no effect.

Reset
- REQ-025 While reset=0 at a clk edge: FSM = IDLE, SR, HB and counter cleared, and sout=0, sout_valid=0, word_done=0, busy=0 from the next cycle.
- REQ-026 in_ready SHALL be 0 while reset=0.
- REQ-027 Reset mid-word SHALL discard any partial SR word and any HB word; no remaining bits are emitted.
- REQ-028 The first accepted word after reset SHALL start from its first bit.

Verification (WIDTH=8 unless stated; cycle 0 = acceptance edge)
- REQ-029 Reset for 2 cycles -> sout=0, sout_valid=0, word_done=0, busy=0, in_ready=0; release -> in_ready=1 and IDLE.
- REQ-030 Single word 8'hD0, MSB_FIRST=1 -> sout 1,1,0,1,0,0,0,0 on cycles 1-8; sout_valid=1 on cycles 1-8; word_done=1 only on cycle 8; sout_valid=0 on cycle 9.
- REQ-031 Back-to-back 8'hC0, 8'h6A, 8'hFF with in_valid held high -> 24 contiguous valid bits with no gap; in_ready low while HB is full; word_done on cycles 8, 16 and 24.
- REQ-032 MSB_FIRST=0, word 8'h03 -> sout 1,1,0,0,0,0,0,0; word_done on cycle 8.
- REQ-033 Reset asserted during bit 4 of 8'hAA with 8'h55 in HB -> sout_valid=0 the next cycle; neither word resumes; next word 8'hF0 emits 1,1,1,1,0,0,0,0 from cycle 1 after its acceptance.
- REQ-034 in_valid=1 with in_ready=0 while in_data toggles 8'h11/8'h22 -> only the value present on the accepting edge is serialized.

Source files
------------

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Converts parallel words into a one-bit-per-clock serial stream. A WIDTH-bit
// shift register (sr) holds the word being emitted and a one-word hold buffer
// (hb) lets the producer hand over the next word early, so consecutive words
// come out back to back with no idle cycle between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is emitted first, 0: bit 0 is emitted first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   in_data     parallel word to serialize
//   in_valid    in_data holds a word
//   in_ready    a word can be taken this cycle (hold buffer empty, not in reset)
//   sout        serial bit, registered; 0 whenever sout_valid is 0
//   sout_valid  sout carries a data bit, registered
//   word_done   registered pulse alongside the last bit of each word
//   busy        shift register or hold buffer occupied
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,  // shift register empty
    SHIFT = 1'b1   // shift register emitting
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [WIDTH-1:0] hb, hb_d;
  logic             hb_full, hb_full_d;
  logic [CNT_W-1:0] cnt, cnt_d;        // index of the bit currently on sout
  logic             sout_d, sout_valid_d, word_done_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;

  // Bit that leaves the word first, given the configured order.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just emitted and bring the next one to the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // in_ready depends on registered state and reset only, never on in_valid,
  // so a producer may legally wait for in_ready before raising in_valid.
  assign in_ready   = reset & ~hb_full;
  assign accept     = in_valid & in_ready;
  assign last_bit   = (state == SHIFT) && (cnt == LAST);
  assign busy       = (state == SHIFT) | hb_full;
  assign sr_shifted = advance(sr);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    if (state == IDLE) begin
      if (accept) state_d = SHIFT;
    end else begin
      // Leave SHIFT only when nothing is queued to follow the last bit.
      if (last_bit && !hb_full && !accept) state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    sr_d         = sr;
    hb_d         = hb;
    hb_full_d    = hb_full;
    cnt_d        = cnt;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    word_done_d  = 1'b0;

    if (state == IDLE) begin
      if (accept) begin
        sr_d         = in_data;
        cnt_d        = '0;
        sout_d       = head(in_data);
        sout_valid_d = 1'b1;
      end
    end else if (!last_bit) begin
      // Mid-word: step to the next bit; a new word waits in the hold buffer.
      sr_d         = sr_shifted;
      cnt_d        = cnt + CNT_W'(1);
      sout_d       = head(sr_shifted);
      sout_valid_d = 1'b1;
      word_done_d  = (cnt_d == LAST);
      if (accept) begin
        hb_d      = in_data;
        hb_full_d = 1'b1;
      end
    end else if (hb_full) begin
      // Last bit out with a word waiting: hand it over with no gap. in_ready
      // is low here, so no new word can arrive in the same cycle.
      sr_d         = hb;
      hb_full_d    = 1'b0;
      cnt_d        = '0;
      sout_d       = head(hb);
      sout_valid_d = 1'b1;
    end else if (accept) begin
      // Last bit out, buffer empty: a word arriving now goes straight to sr.
      sr_d         = in_data;
      cnt_d        = '0;
      sout_d       = head(in_data);
      sout_valid_d = 1'b1;
    end else begin
      sr_d  = '0;
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sr and hb are cleared in reset even though valid flags would mask
  // them, so no fragment of a word in flight survives a reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr         <= '0;
      hb         <= '0;
      hb_full    <= 1'b0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      sr         <= sr_d;
      hb         <= hb_d;
      hb_full    <= hb_full_d;
      cnt        <= cnt_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      word_done  <= word_done_d;
    end
  end

endmodule
